// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_sequencer: iterative signed multiply (shift-add) / divide (restoring)|
// | with its own IDLE->CALC->FIX->DONE sequencer. Option: MULDIV_EARLY_TERM_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             mult_ready,
  output logic             div_ready,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] lo_result
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_a_neg;
  logic               r_neg_res;
  logic [WIDTH-1:0]   r_opa;      // mult: |a| multiplicand; div: dividend shifting into quotient
  logic [WIDTH-1:0]   r_opb;      // mult: |b| multiplier shifting right; div: |b| divisor
  logic [2*WIDTH-1:0] r_acc;      // mult: product; div: remainder in the low half
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_mult_ready;
  logic               r_div_ready;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_take;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mnext;
  logic [2*WIDTH-1:0] w_mult_acc;
  logic               w_mult_done;
  logic [WIDTH:0]     w_dtrial;
  logic [WIDTH:0]     w_ddiff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_drem;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // The most negative operand negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
  assign w_a_mag  = a[WIDTH-1] ? (-a) : a;
  assign w_b_mag  = b[WIDTH-1] ? (-b) : b;
  assign w_take   = mult_start | (div_start & (b != '0));
  assign div_zero = (r_state == S_IDLE) & div_start & ~mult_start & (b == '0);

  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_opb[0] ? {1'b0, r_opa} : '0);
  assign w_mnext = {w_msum, r_acc[WIDTH-1:1]};

  // Partial remainder is always below the divisor, so bit WIDTH of the difference is its sign.
  assign w_dtrial = {r_acc[WIDTH-1:0], r_opa[WIDTH-1]};
  assign w_ddiff  = w_dtrial - {1'b0, r_opb};
  assign w_qbit   = ~w_ddiff[WIDTH];
  assign w_drem   = w_qbit ? w_ddiff[WIDTH-1:0] : w_dtrial[WIDTH-1:0];

`ifdef MULDIV_EARLY_TERM_EN
  logic [CNT_W-1:0] w_shift;
  assign w_shift     = c_last_iter - r_cnt;
  assign w_mult_done = (r_opb[WIDTH-1:1] == '0);
  assign w_mult_acc  = w_mnext >> w_shift;
`else
  assign w_mult_done = (r_cnt == c_last_iter);
  assign w_mult_acc  = w_mnext;
`endif

  assign w_prod = r_neg_res ? (-r_acc) : r_acc;
  assign w_quot = r_neg_res ? (-r_opa) : r_opa;
  assign w_rem  = r_a_neg ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_is_div     <= 1'b0;
      r_a_neg      <= 1'b0;
      r_neg_res    <= 1'b0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_acc        <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_mult_ready <= 1'b0;
      r_div_ready  <= 1'b0;
    end else begin
      r_mult_ready <= 1'b0;
      r_div_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_is_div  <= ~mult_start;
            r_opa     <= w_a_mag;
            r_opb     <= w_b_mag;
            r_a_neg   <= a[WIDTH-1];
            r_neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            r_acc     <= '0;
            r_cnt     <= '0;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_acc[WIDTH-1:0] <= w_drem;
            r_opa            <= {r_opa[WIDTH-2:0], w_qbit};
            if (r_cnt == c_last_iter) r_state <= S_FIX;
          end else begin
            r_acc <= w_mult_acc;
            r_opb <= r_opb >> 1;
            if (w_mult_done) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_mult_ready <= ~r_is_div;
          r_div_ready  <= r_is_div;
          r_cnt        <= '0;
          r_state      <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign mult_ready = r_mult_ready;
  assign div_ready  = r_div_ready;
  assign hi_result  = r_hi;
  assign lo_result  = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, mult_ready, div_ready, div_zero;
  logic [31:0] hi_result, lo_result;

  int checks = 0;
  int errors = 0;

  int lat, nmr, ndr, nbusy, dz;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .mult_ready (mult_ready),
    .div_ready  (div_ready),
    .div_zero   (div_zero),
    .hi_result  (hi_result),
    .lo_result  (lo_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start for a single edge and watch 40 cycles; latency is the cycle index of the first ready.
  task automatic do_op(input logic ms, input logic ds, input logic [31:0] av, input logic [31:0] bv,
                       input logic reassert,
                       output int o_lat, output int o_nmr, output int o_ndr, output int o_nbusy,
                       output int o_dz);
    o_lat = -1; o_nmr = 0; o_ndr = 0; o_nbusy = 0;
    @(negedge clk);
    mult_start = ms; div_start = ds; a = av; b = bv;
    #1 o_dz = int'(div_zero);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) o_nbusy++;
      if (mult_ready) o_nmr++;
      if (div_ready) o_ndr++;
      if ((mult_ready || div_ready) && o_lat < 0) o_lat = i;
      if (i == 1) begin mult_start = 1'b0; div_start = 1'b0; a = '0; b = '0; end
      if (reassert && i == 5) begin mult_start = 1'b1; a = 32'd5; b = 32'd5; end
      if (reassert && i == 6) begin mult_start = 1'b0; a = '0; b = '0; end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mready", 64'(mult_ready), 64'd0);
    check("rst_dready", 64'(div_ready), 64'd0);
    check("rst_hi", 64'(hi_result), 64'd0);
    check("rst_lo", 64'(lo_result), 64'd0);
    reset = 1'b1;

    // 7 * -3 = -21
    do_op(1'b1, 1'b0, 32'd7, -32'sd3, 1'b0, lat, nmr, ndr, nbusy, dz);
    check("m1_dz", 64'(dz), 64'd0);
    check("m1_lat", 64'(lat), 64'd34);
    check("m1_busy", 64'(nbusy), 64'd34);
    check("m1_nmr", 64'(nmr), 64'd1);
    check("m1_ndr", 64'(ndr), 64'd0);
    check("m1_hi", 64'(hi_result), 64'hFFFFFFFF);
    check("m1_lo", 64'(lo_result), 64'hFFFFFFEB);

    // -17 / 5 = -3 rem -2
    do_op(1'b0, 1'b1, -32'sd17, 32'd5, 1'b0, lat, nmr, ndr, nbusy, dz);
    check("d1_lat", 64'(lat), 64'd34);
    check("d1_busy", 64'(nbusy), 64'd34);
    check("d1_nmr", 64'(nmr), 64'd0);
    check("d1_ndr", 64'(ndr), 64'd1);
    check("d1_hi", 64'(hi_result), 64'hFFFFFFFE);
    check("d1_lo", 64'(lo_result), 64'hFFFFFFFD);

    // Divide by zero: flagged, no operation, results untouched
    do_op(1'b0, 1'b1, 32'd100, 32'd0, 1'b0, lat, nmr, ndr, nbusy, dz);
    check("dz_flag", 64'(dz), 64'd1);
    check("dz_busy", 64'(nbusy), 64'd0);
    check("dz_ready", 64'(nmr + ndr), 64'd0);
    check("dz_hi", 64'(hi_result), 64'hFFFFFFFE);
    check("dz_lo", 64'(lo_result), 64'hFFFFFFFD);

    // Both starts: multiply wins, (-2^31)^2 = 2^62
    do_op(1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b0, lat, nmr, ndr, nbusy, dz);
    check("both_dz", 64'(dz), 64'd0);
    check("both_lat", 64'(lat), 64'd34);
    check("both_nmr", 64'(nmr), 64'd1);
    check("both_ndr", 64'(ndr), 64'd0);
    check("both_hi", 64'(hi_result), 64'h40000000);
    check("both_lo", 64'(lo_result), 64'h0);

    // Most negative / -1 wraps
    do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, nmr, ndr, nbusy, dz);
    check("wrap_ndr", 64'(ndr), 64'd1);
    check("wrap_hi", 64'(hi_result), 64'h0);
    check("wrap_lo", 64'(lo_result), 64'h80000000);

    // Reset ten cycles into a divide
    @(negedge clk);
    div_start = 1'b1; a = -32'sd1000; b = 32'd7;
    @(negedge clk);
    div_start = 1'b0; a = '0; b = '0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_ready", 64'({mult_ready, div_ready}), 64'd0);
    check("ar_hi", 64'(hi_result), 64'h0);
    check("ar_lo", 64'(lo_result), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    nmr = 0; ndr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mult_ready) nmr++;
      if (div_ready) ndr++;
    end
    check("ar_no_pulse", 64'(nmr + ndr), 64'd0);
    do_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, lat, nmr, ndr, nbusy, dz);
    check("ar_m_lat", 64'(lat), 64'd34);
    check("ar_m_hi", 64'(hi_result), 64'h0);
    check("ar_m_lo", 64'(lo_result), 64'd12);

    // Start re-asserted while busy is ignored
    do_op(1'b1, 1'b0, 32'h0000FFFF, 32'h00010001, 1'b1, lat, nmr, ndr, nbusy, dz);
    check("rb_lat", 64'(lat), 64'd34);
    check("rb_nmr", 64'(nmr), 64'd1);
    check("rb_busy", 64'(nbusy), 64'd34);
    check("rb_hi", 64'(hi_result), 64'h0);
    check("rb_lo", 64'(lo_result), 64'hFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
